// File: rtl/phase_stats.sv
`default_nettype none
// ============================================================================
// Module      : phase_stats
// Description : Averages a run of 2^n phase-difference samples, tracking
//               min/max and counting samples whose redundant byte copies
//               disagree. Results are held until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_stats #(
    parameter int N_LOG2_MAX = 8
) (
    input  logic        clk_fast,
    input  logic        reset,
    input  logic [15:0] phase_diff,
    input  logic        meas_done,
    input  logic        arm,
    input  logic [3:0]  n_log2,
    input  logic        result_ack,
    output logic [7:0]  avg,
    output logic [7:0]  min_out,
    output logic [7:0]  max_out,
    output logic        result_valid,
    output logic        busy,
    output logic [7:0]  mismatch_cnt
);

    // Sample counter must reach 2^N_LOG2_MAX itself, hence one extra bit.
    localparam int c_CNT_W = N_LOG2_MAX + 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCUM  = 2'd1;
    localparam logic [1:0] c_ST_FINISH = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [3:0]         r_n_log2;
    logic [3:0]         w_n_clamped;
    logic [15:0]        r_acc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_target;
    logic [7:0]         r_min;
    logic [7:0]         r_max;
    logic [7:0]         r_avg;
    logic [7:0]         r_min_out;
    logic [7:0]         r_max_out;
    logic [7:0]         r_mism;
    logic [7:0]         w_sample;
    logic               w_match;
    logic               w_in_accum;
    logic               w_accept;
    logic               w_reject;
    logic               w_last;

    assign w_sample   = phase_diff[7:0];
    assign w_match    = (phase_diff[15:8] == phase_diff[7:0]);
    // arm outranks a coincident meas_done: the sample is simply dropped.
    assign w_in_accum = (r_state == c_ST_ACCUM) && meas_done && !arm;
    assign w_accept   = w_in_accum && w_match;
    assign w_reject   = w_in_accum && !w_match;
    assign w_target   = c_CNT_W'(1) << r_n_log2;
    assign w_last     = w_accept && ((r_count + c_CNT_W'(1)) == w_target);
    assign w_n_clamped = (32'(n_log2) > N_LOG2_MAX) ? 4'(N_LOG2_MAX) : n_log2;

    // State register.
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; arm restarts a run from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = c_ST_ACCUM;
        end else begin
            case (r_state)
                c_ST_IDLE:   w_state_nxt = c_ST_IDLE;
                c_ST_ACCUM:  if (w_last) w_state_nxt = c_ST_FINISH;
                c_ST_FINISH: w_state_nxt = c_ST_DONE;
                c_ST_DONE:   if (result_ack) w_state_nxt = c_ST_IDLE;
                default:     w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Accumulation datapath and result registers.
    always_ff @(posedge clk_fast) begin
        if (reset) begin
            r_n_log2  <= 4'd0;
            r_acc     <= 16'd0;
            r_count   <= '0;
            r_min     <= 8'd0;
            r_max     <= 8'd0;
            r_mism    <= 8'd0;
            r_avg     <= 8'd0;
            r_min_out <= 8'd0;
            r_max_out <= 8'd0;
        end else if (arm) begin
            r_n_log2 <= w_n_clamped;
            r_acc    <= 16'd0;
            r_count  <= '0;
            r_min    <= 8'hFF;
            r_max    <= 8'h00;
            r_mism   <= 8'd0;
        end else begin
            if (w_accept) begin
                r_acc   <= r_acc + {8'd0, w_sample};
                r_count <= r_count + c_CNT_W'(1);
                if (w_sample < r_min) r_min <= w_sample;
                if (w_sample > r_max) r_max <= w_sample;
            end
            if (w_reject && (r_mism != 8'hFF)) begin
                r_mism <= r_mism + 8'd1;
            end
            // Published results only change here, so they survive ack
            // and the whole of the next run's accumulation.
            if (r_state == c_ST_FINISH) begin
                r_avg     <= 8'(r_acc >> r_n_log2);
                r_min_out <= r_min;
                r_max_out <= r_max;
            end
        end
    end

    assign avg          = r_avg;
    assign min_out      = r_min_out;
    assign max_out      = r_max_out;
    assign mismatch_cnt = r_mism;
    assign result_valid = (r_state == c_ST_DONE);
    assign busy         = (r_state == c_ST_ACCUM) || (r_state == c_ST_FINISH);

endmodule
`default_nettype wire

// File: tb/tb_phase_stats.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_stats
// Description : Scoreboard bench for phase_stats with a queue-based
//               reference model of each averaging run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_stats;

    logic        clk_fast = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] phase_diff = 16'd0;
    logic        meas_done = 1'b0;
    logic        arm = 1'b0;
    logic [3:0]  n_log2 = 4'd0;
    logic        result_ack = 1'b0;
    logic [7:0]  avg;
    logic [7:0]  min_out;
    logic [7:0]  max_out;
    logic        result_valid;
    logic        busy;
    logic [7:0]  mismatch_cnt;

    phase_stats #(.N_LOG2_MAX(8)) dut (
        .clk_fast     (clk_fast),
        .reset        (reset),
        .phase_diff   (phase_diff),
        .meas_done    (meas_done),
        .arm          (arm),
        .n_log2       (n_log2),
        .result_ack   (result_ack),
        .avg          (avg),
        .min_out      (min_out),
        .max_out      (max_out),
        .result_valid (result_valid),
        .busy         (busy),
        .mismatch_cnt (mismatch_cnt)
    );

    always #5 clk_fast = ~clk_fast;

    int cyc = 0;
    always @(posedge clk_fast) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] avg;
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] mism;
        int         rise;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state for the run in progress.
    logic [7:0] m_samples[$];
    int         m_n;
    int         m_target;
    int         m_mism;
    bit         m_active = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever a result appears, compare it with the oldest expectation.
    bit prev_v = 0;
    always @(negedge clk_fast) begin
        if (result_valid && !prev_v) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("avg", 32'(avg), 32'(e.avg));
                check("min_out", 32'(min_out), 32'(e.mn));
                check("max_out", 32'(max_out), 32'(e.mx));
                check("mismatch_cnt", 32'(mismatch_cnt), 32'(e.mism));
                check("valid_rise_cycle", 32'(cyc), 32'(e.rise));
            end
        end
        prev_v = result_valid;
    end

    task automatic m_arm(input int n);
        m_n      = (n > 8) ? 8 : n;
        m_target = 1 << m_n;
        m_samples.delete();
        m_mism   = 0;
        m_active = 1;
    endtask

    task automatic m_feed(input logic [15:0] pd);
        int   sum;
        exp_t e;
        if (!m_active) return;
        if (pd[15:8] == pd[7:0]) begin
            m_samples.push_back(pd[7:0]);
            if (m_samples.size() == m_target) begin
                sum  = 0;
                e.mn = 8'hFF;
                e.mx = 8'h00;
                foreach (m_samples[i]) begin
                    sum += int'(m_samples[i]);
                    if (m_samples[i] < e.mn) e.mn = m_samples[i];
                    if (m_samples[i] > e.mx) e.mx = m_samples[i];
                end
                e.avg    = 8'(sum / m_target);
                e.mism   = 8'(m_mism);
                e.rise   = cyc + 1;
                sb.push_back(e);
                last_exp = e;
                m_active = 0;
            end
        end else if (m_mism < 255) begin
            m_mism++;
        end
    endtask

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic do_arm(input int n);
        arm    = 1'b1;
        n_log2 = 4'(n);
        tick();
        arm = 1'b0;
        m_arm(n);
        check("busy_after_arm", 32'(busy), 32'd1);
        check("valid_after_arm", 32'(result_valid), 32'd0);
        check("mism_after_arm", 32'(mismatch_cnt), 32'd0);
    endtask

    task automatic feed(input logic [15:0] pd);
        meas_done  = 1'b1;
        phase_diff = pd;
        tick();
        meas_done = 1'b0;
        m_feed(pd);
    endtask

    function automatic logic [15:0] rand_sample(input bit allow_bad);
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (allow_bad && ($urandom_range(0, 4) == 0))
            return {v ^ 8'($urandom_range(1, 255)), v};
        return {v, v};
    endfunction

    task automatic wait_result();
        int k = 0;
        while (!result_valid && k < 50) begin
            tick();
            k++;
        end
        check("result_seen", 32'(result_valid), 32'd1);
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("valid_after_ack", 32'(result_valid), 32'd0);
        check("busy_after_ack", 32'(busy), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_avg"}, 32'(avg), 32'd0);
        check({tag, "_min"}, 32'(min_out), 32'd0);
        check({tag, "_max"}, 32'(max_out), 32'd0);
        check({tag, "_mism"}, 32'(mismatch_cnt), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic random_run(input int n, input bit gaps);
        do_arm(n);
        while (m_active) begin
            feed(rand_sample(1'b1));
            if (gaps) begin
                if ($urandom_range(0, 7) == 0) begin
                    // Acknowledge while no result is held must do nothing.
                    result_ack = 1'b1;
                    tick();
                    result_ack = 1'b0;
                end
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        wait_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        check_zero("reset");

        // Directed: four clean samples, n=2.
        do_arm(2);
        feed(16'h0A0A); feed(16'h0C0C); feed(16'h0808); feed(16'h0E0E);
        wait_result();
        check("d1_avg_const", 32'(avg), 32'h0B);
        do_ack();

        // Directed: one mismatched sample rejected, n=1.
        do_arm(1);
        feed(16'h0505); feed(16'h0506);
        check("d2_mism_mid", 32'(mismatch_cnt), 32'd1);
        feed(16'h0707);
        wait_result();
        do_ack();

        // Directed: n=0 completes on a single sample, including value 0.
        do_arm(0);
        feed(16'h0000);
        wait_result();
        do_ack();

        // Full-scale run: 256 x 0xFF must not wrap.
        do_arm(8);
        repeat (256) feed(16'hFFFF);
        wait_result();
        check("d3_avg_const", 32'(avg), 32'hFF);
        do_ack();

        // Requested n beyond the limit clamps to 256 samples.
        do_arm(12);
        repeat (255) feed(rand_sample(1'b0));
        check("clamp_busy_before_last", 32'(busy), 32'd1);
        feed(rand_sample(1'b0));
        wait_result();
        do_ack();

        // Mismatch counter saturates at 255.
        do_arm(1);
        repeat (300) feed(16'h1234);
        check("mism_saturate", 32'(mismatch_cnt), 32'd255);
        feed(16'h4040); feed(16'h2020);
        wait_result();
        do_ack();

        // arm together with meas_done: that sample is dropped.
        arm = 1'b1; n_log2 = 4'd1; meas_done = 1'b1; phase_diff = 16'h0101;
        tick();
        arm = 1'b0; meas_done = 1'b0;
        m_arm(1);
        feed(16'h0202); feed(16'h0404);
        wait_result();

        // Hold with no ack for 100 cycles while meas_done keeps pulsing.
        for (int i = 0; i < 100; i++) begin
            meas_done  = ($urandom_range(0, 1) == 1);
            phase_diff = rand_sample(1'b1);
            tick();
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_avg", 32'(avg), 32'(last_exp.avg));
            check("hold_min", 32'(min_out), 32'(last_exp.mn));
            check("hold_max", 32'(max_out), 32'(last_exp.mx));
            check("hold_mism", 32'(mismatch_cnt), 32'(last_exp.mism));
        end
        meas_done = 1'b0;
        do_ack();

        // Results survive ack and a new run's accumulation.
        do_arm(2);
        check("keep_avg", 32'(avg), 32'(last_exp.avg));
        check("keep_min", 32'(min_out), 32'(last_exp.mn));
        feed(16'h0303); feed(16'h0505); feed(16'h0707);
        check("keep_max", 32'(max_out), 32'(last_exp.mx));
        feed(16'h0909);
        wait_result();

        // arm and ack together in DONE: arm wins.
        arm = 1'b1; n_log2 = 4'd1; result_ack = 1'b1;
        tick();
        arm = 1'b0; result_ack = 1'b0;
        m_arm(1);
        check("arm_over_ack_busy", 32'(busy), 32'd1);
        check("arm_over_ack_valid", 32'(result_valid), 32'd0);
        feed(16'h1111); feed(16'h3333);
        wait_result();
        do_ack();

        // Randomized runs.
        for (int r = 0; r < 8; r++) random_run($urandom_range(0, 4), 1'b1);
        // Leave the last random result held; do not ack yet.
        random_run(3, 1'b0);

        // Reset mid-run abandons it and clears everything.
        arm = 1'b1; n_log2 = 4'd2; meas_done = 1'b1; phase_diff = 16'h5555;
        tick();
        arm = 1'b0; meas_done = 1'b0;
        m_arm(2);
        feed(16'h2222); feed(16'h3334);
        feed(16'h3333);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_active = 0;
        check_zero("midrun_reset");
        feed(16'h4444); feed(16'h4445);
        repeat (3) tick();
        check_zero("after_reset_meas");

        // Reset overrides a coincident arm.
        reset = 1'b1; arm = 1'b1; n_log2 = 4'd1;
        tick();
        reset = 1'b0; arm = 1'b0;
        check_zero("reset_over_arm");
        feed(16'h0606);
        repeat (3) tick();
        check("reset_over_arm_idle", 32'(busy), 32'd0);

        repeat (3) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phase_stats.md
PHASE_STATS -- requirements
Module: phase_stats

Interface
REQ-001 SHALL have parameter N_LOG2_MAX, default 8, giving the largest allowed log2 of the sample count.
REQ-002 SHALL have port clk_fast  input  1  clock; same clock that drives the phase-difference counter.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port phase_diff  input  16  measurement word from the phase counter; [7:0] and [15:8] are redundant copies of one count.
REQ-005 SHALL have port meas_done  input  1  single-cycle pulse; phase_diff is final in the same cycle.
REQ-006 SHALL have port arm  input  1  single-cycle pulse that starts a new averaging run.
REQ-007 SHALL have port n_log2  input  4  log2 of samples per run, latched on accepted arm.
REQ-008 SHALL have port result_ack  input  1  consumer acknowledge of a result.
REQ-009 SHALL have port avg  output  8  mean of accepted samples.
REQ-010 SHALL have port min_out  output  8  smallest accepted sample.
REQ-011 SHALL have port max_out  output  8  largest accepted sample.
REQ-012 SHALL have port result_valid  output  1  result registers hold a completed run.
REQ-013 SHALL have port busy  output  1  high in ACCUM and FINISH.
REQ-014 SHALL have port mismatch_cnt  output  8  count of rejected samples in the current or last run.

Function
REQ-015 SHALL implement states IDLE, ACCUM, FINISH and DONE, with all transitions on clk_fast rising edges.
REQ-016 SHALL, on arm in any state, enter ACCUM and clear the accumulator (16 bit), sample count, and mismatch_cnt.
REQ-017 SHALL, on arm, set internal running min to 0xFF and running max to 0x00, latch min(n_log2, N_LOG2_MAX), and deassert result_valid.
REQ-018 SHALL, in ACCUM on meas_done with phase_diff[15:8]==phase_diff[7:0], accept phase_diff[7:0]: add it to the accumulator, update running min/max, and increment the sample count.
REQ-019 SHALL, in ACCUM on meas_done with phase_diff[15:8]!=phase_diff[7:0], discard the sample and increment mismatch_cnt, saturating at 255; the sample count is unchanged.
REQ-020 SHALL treat a sample value of 0 as a valid sample.
REQ-021 SHALL move from ACCUM to FINISH on the edge that accepts sample number 2^n_log2 (the latched value).
REQ-022 SHALL, in FINISH, load avg = accumulator >> n_log2 (truncating), min_out, and max_out; enter DONE and assert result_valid on that edge, one cycle after the final accepted meas_done.
REQ-023 SHALL, for n_log2 = 0, complete the run after one sample, with avg = min_out = max_out = that sample.
REQ-024 SHALL, in DONE, hold result_valid high until result_ack is sampled high, then deassert result_valid and enter IDLE.
REQ-025 SHALL ignore result_ack whenever result_valid is low.
REQ-026 SHALL ignore meas_done in IDLE, FINISH and DONE.
REQ-027 SHALL, when arm and meas_done occur in the same cycle, give arm priority and discard the sample.
REQ-028 SHALL, when arm and result_ack occur together in DONE, give arm priority and enter ACCUM.
REQ-029 SHALL hold avg, min_out and max_out unchanged after ack and through a new run until that run's FINISH.
REQ-030 SHALL never overflow the accumulator, since 2^8 samples x 255 fits in 16 bits.

Reset
REQ-031 SHALL, on reset high at a clock edge, enter IDLE and set avg, min_out, max_out, mismatch_cnt, result_valid and busy to 0, clearing all internal accumulation state.
REQ-032 SHALL, on reset during ACCUM or DONE, abandon the run with no result produced; reset overrides arm.

Verification
REQ-033 SHALL pass: arm with n_log2=2, then meas_done with phase_diff 0x0A0A, 0x0C0C, 0x0808, 0x0E0E -> result_valid rises one cycle after the 4th pulse; avg=0x0B, min_out=0x08, max_out=0x0E, mismatch_cnt=0.
REQ-034 SHALL pass: arm with n_log2=1, then samples 0x0505, 0x0506, 0x0707 -> the 0x0506 sample is rejected; mismatch_cnt=1; avg=0x06, min_out=0x05, max_out=0x07.
REQ-035 SHALL pass: arm with n_log2=8, then 256 samples of 0xFFFF -> avg=0xFF, min_out=max_out=0xFF, and no accumulator wrap.
REQ-036 SHALL pass: arm with n_log2=12 -> run clamps to 256 samples and completes exactly on the 256th accepted sample.
REQ-037 SHALL pass: arm and meas_done in the same cycle, then reset asserted mid-run after 2 samples -> first sample not counted; after reset all outputs are 0 and the state is IDLE; a further meas_done has no effect.
REQ-038 SHALL pass: result_valid held with no result_ack for 100 cycles, extra meas_done pulses, then result_ack -> outputs stable throughout; result_valid falls on the edge after ack.
